// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the small CPU: default address/data widths used by
// the fetch unit, IR, register file and control unit, the opcode constants,
// and the fetch state encoding.
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W = 8;
  localparam int unsigned CPU_DATA_W = 16;

  // Opcode that stops the fetch stage.
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    FS_IDLE  = 3'd0,
    FS_REQ   = 3'd1,
    FS_WRITE = 3'd2,
    FS_EXEC  = 3'd3,
    FS_HALT  = 3'd4
  } fetch_state_e;

endpackage : cpu_pkg

// File: rtl/fetch_pc_counter.sv
// ---------------------------------------------------------------------------
// fetch_pc_counter
// Program counter register for the fetch stage. Load has priority over
// increment; increment wraps modulo 2^ADDR_W.
// Ports:
//   clk          in   clock, rising edge
//   rst_n        in   asynchronous active-low reset (pc -> RESET_PC)
//   inc_i        in   advance pc by one
//   load_i       in   load load_addr_i into pc
//   load_addr_i  in   jump/branch target
//   pc_o         out  current pc (registered)
// ---------------------------------------------------------------------------
module fetch_pc_counter
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = CPU_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inc_i,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] load_addr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;

  // Next pc: load wins over increment, otherwise hold.
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_addr_i;
    end else if (inc_i) begin
      pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else begin
      pc_d = pc_q;
    end
  end

  // PC register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule : fetch_pc_counter

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage feeding the instruction register. Owns the PC,
// reads instruction memory over a req/valid handshake, presents each word to
// the IR with a one-cycle write strobe, then waits for the downstream stage
// (next_ready) before fetching again. Jumps/branches load the PC while the
// instruction executes. Fetching stops on the HALT opcode.
//
// Optional feature: define FETCH_TIMEOUT_EN to abort a request that is not
// answered within TIMEOUT_CYC cycles (fetch_err set, sticky, go to HALT).
// Without it the request waits indefinitely and fetch_err is tied low.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   run             start/continue fetching
//   imem_req/addr   memory read request (held until imem_valid) and address
//   imem_valid/rdata memory response
//   ir_din          last fetched word, ir_write_en one-cycle IR load strobe
//   next_ready      downstream finished the current instruction
//   pc_load/addr    PC load request (honoured only while executing)
//   pc, halted      current PC, HALT state indication
//   fetch_err       request timeout flag
// ---------------------------------------------------------------------------
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned       ADDR_W   = CPU_ADDR_W,
  parameter int unsigned       DATA_W   = CPU_DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [3:0]        HALT_OP  = OP_HALT
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int unsigned       TIMEOUT_CYC = 15
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] ir_din,
  output logic              ir_write_en,
  input  logic              next_ready,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fetch_err
);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [DATA_W-1:0] ir_din_q;
  logic [DATA_W-1:0] ir_din_d;
  logic              pc_inc_s;
  logic              pc_load_s;
  logic [ADDR_W-1:0] pc_s;
  logic [3:0]        opcode_s;
  logic              tmo_hit_s;

  assign opcode_s = ir_din_q[DATA_W-1 -: 4];

  fetch_pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk         (clk),
    .rst_n       (rst),
    .inc_i       (pc_inc_s),
    .load_i      (pc_load_s),
    .load_addr_i (pc_load_addr),
    .pc_o        (pc_s)
  );

`ifdef FETCH_TIMEOUT_EN
  logic [3:0] tmo_cnt_q;
  logic [3:0] tmo_cnt_d;
  logic       err_q;
  logic       err_d;

  // Timeout counter: counts unanswered REQ cycles, zero whenever outside REQ
  // so every new request starts from zero.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    err_d     = err_q;
    tmo_hit_s = 1'b0;
    if ((state_q == FS_REQ) && !imem_valid) begin
      if (tmo_cnt_q == 4'(TIMEOUT_CYC - 1)) begin
        tmo_hit_s = 1'b1;
        err_d     = 1'b1;
        tmo_cnt_d = 4'(TIMEOUT_CYC);
      end else begin
        tmo_cnt_d = tmo_cnt_q + 4'd1;
      end
    end else if (state_q != FS_REQ) begin
      tmo_cnt_d = 4'd0;
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Timeout counter and sticky error flag registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_cnt_q <= 4'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign tmo_hit_s = 1'b0;
  assign fetch_err = 1'b0;
`endif

  // Next-state, IR capture and PC control.
  always_comb begin
    state_d   = state_q;
    ir_din_d  = ir_din_q;
    pc_inc_s  = 1'b0;
    pc_load_s = 1'b0;
    case (state_q)
      FS_IDLE: begin
        if (run) begin
          state_d = FS_REQ;
        end else begin
          state_d = FS_IDLE;
        end
      end
      FS_REQ: begin
        // A response always beats a timeout in the same cycle.
        if (imem_valid) begin
          ir_din_d = imem_rdata;
          state_d  = FS_WRITE;
        end else if (tmo_hit_s) begin
          state_d = FS_HALT;
        end else begin
          state_d = FS_REQ;
        end
      end
      FS_WRITE: begin
        pc_inc_s = 1'b1;
        if (opcode_s == HALT_OP) begin
          state_d = FS_HALT;
        end else begin
          state_d = FS_EXEC;
        end
      end
      FS_EXEC: begin
        // A load in the same cycle as next_ready lands before the next REQ.
        pc_load_s = pc_load;
        if (next_ready) begin
          state_d = run ? FS_REQ : FS_IDLE;
        end else begin
          state_d = FS_EXEC;
        end
      end
      FS_HALT: begin
        if (!run) begin
          state_d = FS_IDLE;
        end else begin
          state_d = FS_HALT;
        end
      end
      default: begin
        state_d = FS_IDLE;
      end
    endcase
  end

  // State and IR data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= FS_IDLE;
      ir_din_q <= '0;
    end else begin
      state_q  <= state_d;
      ir_din_q <= ir_din_d;
    end
  end

  // Control outputs are pure decodes of the state register.
  assign imem_req    = (state_q == FS_REQ);
  assign imem_addr   = pc_s;
  assign ir_write_en = (state_q == FS_WRITE);
  assign halted      = (state_q == FS_HALT);
  assign ir_din      = ir_din_q;
  assign pc          = pc_s;

endmodule : fetch_unit

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
// Directed bench for fetch_unit. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_rdata;
  logic [15:0] ir_din;
  logic        ir_write_en;
  logic        next_ready;
  logic        pc_load;
  logic [7:0]  pc_load_addr;
  logic [7:0]  pc;
  logic        halted;
  logic        fetch_err;

  int n_checks;
  int n_errors;

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .run          (run),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_valid   (imem_valid),
    .imem_rdata   (imem_rdata),
    .ir_din       (ir_din),
    .ir_write_en  (ir_write_en),
    .next_ready   (next_ready),
    .pc_load      (pc_load),
    .pc_load_addr (pc_load_addr),
    .pc           (pc),
    .halted       (halted),
    .fetch_err    (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Entered at a falling edge with the DUT in REQ for exp_addr. Answers after
  // 'delay' idle cycles and leaves the DUT in EXEC (or HALT).
  task automatic do_fetch(input logic [7:0] exp_addr, input logic [15:0] word, input int delay);
    logic [7:0] next_pc;
    logic       exp_halt;
    next_pc  = exp_addr + 8'd1;
    exp_halt = (word[15:12] == 4'hF);
    check("req_asserted", imem_req, 1'b1);
    check("req_addr", imem_addr, exp_addr);
    for (int i = 0; i < delay; i++) begin
      step();
      check("req_held", imem_req, 1'b1);
      check("addr_stable", imem_addr, exp_addr);
      check("no_strobe_wait", ir_write_en, 1'b0);
    end
    imem_valid = 1'b1;
    imem_rdata = word;
    step();
    imem_valid = 1'b0;
    imem_rdata = 16'hBAD0;
    check("strobe_on", ir_write_en, 1'b1);
    check("ir_din", ir_din, word);
    check("req_drop", imem_req, 1'b0);
    step();
    check("strobe_off", ir_write_en, 1'b0);
    check("pc_inc", pc, next_pc);
    check("halted_after_write", halted, exp_halt);
    check("no_req_after_write", imem_req, 1'b0);
    check("ir_din_hold", ir_din, word);
  endtask

  // From EXEC: signal next_ready (optionally with a PC load) -> REQ.
  task automatic exec_next(input logic load, input logic [7:0] addr);
    pc_load      = load;
    pc_load_addr = addr;
    next_ready   = 1'b1;
    step();
    pc_load    = 1'b0;
    next_ready = 1'b0;
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b0;
    run          = 1'b0;
    imem_valid   = 1'b0;
    imem_rdata   = 16'h0000;
    next_ready   = 1'b0;
    pc_load      = 1'b0;
    pc_load_addr = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 1'b0);
    check("rst_pc", pc, 8'h00);
    check("rst_ir", ir_din, 16'h0000);
    check("rst_we", ir_write_en, 1'b0);
    check("rst_halted", halted, 1'b0);
    check("rst_err", fetch_err, 1'b0);

    // 1: back-to-back fetches with same-cycle response
    rst = 1'b1;
    run = 1'b1;
    step();
    do_fetch(8'h00, 16'h1234, 0);
    exec_next(1'b0, 8'h00);
    do_fetch(8'h01, 16'h5678, 0);
    exec_next(1'b0, 8'h00);

    // 2: response delayed by 4 cycles
    do_fetch(8'h02, 16'h2222, 4);

    // 3: PC load in EXEC, last load wins, load with next_ready
    pc_load      = 1'b1;
    pc_load_addr = 8'h10;
    step();
    pc_load = 1'b0;
    check("load_in_exec", pc, 8'h10);
    check("exec_no_req", imem_req, 1'b0);
    exec_next(1'b1, 8'h40);
    do_fetch(8'h40, 16'h3333, 0);

    // 5: PC wrap from 0xFF
    exec_next(1'b1, 8'hFF);
    do_fetch(8'hFF, 16'h4444, 0);
    check("pc_wrapped", pc, 8'h00);
    exec_next(1'b0, 8'h00);

    // 4: HALT opcode
    do_fetch(8'h00, 16'hF000, 0);
    pc_load      = 1'b1;
    pc_load_addr = 8'h77;
    imem_valid   = 1'b1;
    imem_rdata   = 16'h9999;
    repeat (3) step();
    pc_load    = 1'b0;
    imem_valid = 1'b0;
    check("halt_stays", halted, 1'b1);
    check("halt_no_req", imem_req, 1'b0);
    check("halt_pc_held", pc, 8'h01);
    check("halt_ir_held", ir_din, 16'hF000);
    run = 1'b0;
    step();
    check("halt_to_idle", halted, 1'b0);
    check("idle_no_req", imem_req, 1'b0);
    check("idle_pc_held", pc, 8'h01);

    // run=0 at next_ready returns to IDLE
    run = 1'b1;
    step();
    do_fetch(8'h01, 16'h0ABC, 0);
    run = 1'b0;
    exec_next(1'b0, 8'h00);
    step();
    check("exec_to_idle_req", imem_req, 1'b0);
    check("exec_to_idle_pc", pc, 8'h02);

    // 6: asynchronous reset during REQ, late valid ignored
    run = 1'b1;
    step();
    check("pre_rst_req", imem_req, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_req", imem_req, 1'b0);
    check("async_rst_pc", pc, 8'h00);
    check("async_rst_ir", ir_din, 16'h0000);
    run        = 1'b0;
    imem_valid = 1'b1;
    imem_rdata = 16'hDEAD;
    @(negedge clk);
    imem_valid = 1'b0;
    rst        = 1'b1;
    step();
    check("late_valid_ir", ir_din, 16'h0000);
    check("late_valid_we", ir_write_en, 1'b0);
    check("late_valid_req", imem_req, 1'b0);

`ifdef FETCH_TIMEOUT_EN
    // Timeout: no response for 15 REQ cycles
    run = 1'b1;
    step();
    check("tmo_req", imem_req, 1'b1);
    for (int i = 0; i < 14; i++) begin
      step();
    end
    check("tmo_still_req", imem_req, 1'b1);
    check("tmo_no_err_yet", fetch_err, 1'b0);
    step();
    check("tmo_err", fetch_err, 1'b1);
    check("tmo_halted", halted, 1'b1);
    check("tmo_req_drop", imem_req, 1'b0);
    run = 1'b0;
    step();
    check("tmo_err_sticky", fetch_err, 1'b1);
`else
    check("err_tied_low", fetch_err, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_fetch_unit
